// File: rtl/jtag_pkg.sv
// Shared instruction codes, capture pattern and action encoding for the JTAG instruction register.
// No timing of its own; no backpressure.
package jtag_pkg;

    localparam int unsigned IR_MIN_WIDTH = 2;
    localparam int unsigned IR_MAX_WIDTH = 16;

    localparam logic [IR_MAX_WIDTH-1:0] EXTEST = 16'h0000;
    localparam logic [IR_MAX_WIDTH-1:0] IDCODE = 16'h0001;
    localparam logic [IR_MAX_WIDTH-1:0] SAMPLE = 16'h0002;
    localparam logic [IR_MAX_WIDTH-1:0] BYPASS = 16'hFFFF;

    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    // One action per TCK edge, already resolved by priority.
    typedef enum logic [2:0] {
        ACT_IDLE    = 3'd0,
        ACT_RESET   = 3'd1,
        ACT_CAPTURE = 3'd2,
        ACT_SHIFT   = 3'd3,
        ACT_UPDATE  = 3'd4
    } ir_act_e;

    function automatic logic [IR_MAX_WIDTH-1:0] ir_bypass(input int unsigned width);
        logic [IR_MAX_WIDTH-1:0] code;
        code = '0;
        for (int unsigned k = 0; k < IR_MAX_WIDTH; k++) begin
            if (k < width) begin
                code[k] = 1'b1;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/jtag_ir_sync_if.sv
// TAP-side bundle for the instruction register: enables, serial data, status and decoded instruction.
// Purely wiring; no latency, no backpressure.
interface jtag_ir_sync_if #(
    parameter int unsigned IR_WIDTH = 3
);
    logic                TDI;
    logic                Capture_IR;
    logic                Shift_IR;
    logic                Update_IR;
    logic [IR_WIDTH-1:0] Status_in;
    logic                TDO;
    logic                TDO_en;
    logic [IR_WIDTH-1:0] I_CODE;
    logic                Len_err;

    modport master (
        output TDI, Capture_IR, Shift_IR, Update_IR, Status_in,
        input  TDO, TDO_en, I_CODE, Len_err
    );

    modport slave (
        input  TDI, Capture_IR, Shift_IR, Update_IR, Status_in,
        output TDO, TDO_en, I_CODE, Len_err
    );
endinterface

// File: rtl/jtag_ir_cell_sync.sv
// One instruction-register bit: reset load, parallel capture or serial shift on rising TCK.
// Latency one TCK edge; no backpressure (enables are pre-resolved by the parent).
module jtag_ir_cell_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic capture,
    input  logic shift,
    input  logic reset_val,
    input  logic capture_val,
    input  logic shift_in,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= reset_val;
        end else if (capture) begin
            q <= capture_val;
        end else if (shift) begin
            q <= shift_in;
        end
    end

endmodule

// File: rtl/jtag_ir_sync.sv
// JTAG instruction register: capture/shift stage, shadow I_CODE with illegal-opcode-to-BYPASS and shift-length check.
// TDI reaches TDO after IR_WIDTH shifts, I_CODE updates one edge after Update_IR; no backpressure.
module jtag_ir_sync
    import jtag_pkg::*;
#(
    parameter int unsigned                IR_WIDTH   = 3,
    parameter logic [IR_WIDTH-1:0]        RESET_CODE = IR_WIDTH'(IDCODE),
    parameter logic [(2**IR_WIDTH)-1:0]   VALID_MASK = '1
) (
    input  logic          TCK,
    input  logic          Test_Log_Res_n,
    jtag_ir_sync_if.slave bus
);

    localparam int unsigned CW = $clog2(IR_WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(IR_WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(IR_WIDTH + 1);
    localparam logic [IR_WIDTH-1:0] BYPASS_CODE = IR_WIDTH'(ir_bypass(IR_WIDTH));

    ir_act_e             act;
    logic [IR_WIDTH-1:0] sr;
    logic [CW-1:0]       bit_cnt;
    logic                do_capture;
    logic                do_shift;
    logic                opcode_ok;
    logic                unused_status;

    // Capture bits [1:0] are the fixed 01 pattern, so the matching status bits are dropped.
    assign unused_status = ^bus.Status_in[1:0];

    always_comb begin
        act = ACT_IDLE;
        if (!Test_Log_Res_n) begin
            act = ACT_RESET;
        end else if (bus.Capture_IR) begin
            act = ACT_CAPTURE;
        end else if (bus.Shift_IR) begin
            act = ACT_SHIFT;
        end else if (bus.Update_IR) begin
            act = ACT_UPDATE;
        end
    end

    assign do_capture = (act == ACT_CAPTURE);
    assign do_shift   = (act == ACT_SHIFT);

    for (genvar i = 0; i < IR_WIDTH; i++) begin : g_cell
        logic cap_bit;
        logic nxt_bit;

        if (i < 2) begin : g_lsb
            assign cap_bit = IR_CAPTURE_LSBS[i];
        end else begin : g_status
            assign cap_bit = bus.Status_in[i];
        end

        if (i == IR_WIDTH - 1) begin : g_msb
            assign nxt_bit = bus.TDI;
        end else begin : g_chain
            assign nxt_bit = sr[i+1];
        end

        jtag_ir_cell_sync u_cell (
            .clk         (TCK),
            .rst_n       (Test_Log_Res_n),
            .capture     (do_capture),
            .shift       (do_shift),
            .reset_val   (i == 0),
            .capture_val (cap_bit),
            .shift_in    (nxt_bit),
            .q           (sr[i])
        );
    end

    assign opcode_ok = VALID_MASK[sr];
    assign bus.TDO   = sr[0];

    always_ff @(posedge TCK) begin
        if (!Test_Log_Res_n) begin
            bus.I_CODE  <= RESET_CODE;
            bus.TDO_en  <= 1'b0;
            bus.Len_err <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            bus.TDO_en <= bus.Shift_IR;
            case (act)
                ACT_CAPTURE: bit_cnt <= '0;
                ACT_SHIFT: begin
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                // Update always commits; a wrong length is only flagged.
                ACT_UPDATE: begin
                    bus.I_CODE  <= opcode_ok ? sr : BYPASS_CODE;
                    bus.Len_err <= (bit_cnt != CNT_FULL);
                    bit_cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/jtag_ir_sync.md
Name: jtag_ir_sync

Overview:
- Parametrised, single-clock JTAG instruction register for the TAP controller datapath.
- Provides a capture/shift/update shift stage plus a shadow (instruction) register of IR_WIDTH bits.
- Adds things the fixed 3-bit IR lacked:
  - status capture;
  - illegal-opcode substitution to BYPASS;
  - shift-length checking.
- Sits between the TAP state machine (which supplies Capture_IR/Shift_IR/Update_IR enables) and the instruction decoder.

Parameters:
- IR_WIDTH, 3, instruction length in bits; legal range 2..16.
- RESET_CODE, 1, value loaded into I_CODE on reset (IDCODE).
- VALID_MASK, all ones (2**IR_WIDTH bits), bit k=1 means opcode k is implemented.

Ports:
- TCK  input  1  test clock; all state changes on rising edge.
- Test_Log_Res_n  input  1  synchronous active-low reset (Test-Logic-Reset).
- TDI  input  1  serial data in.
- Capture_IR  input  1  TAP in Capture-IR.
- Shift_IR  input  1  TAP in Shift-IR.
- Update_IR  input  1  TAP in Update-IR.
- Status_in  input  IR_WIDTH  status bits captured into bits [IR_WIDTH-1:2]; bits [1:0] ignored.
- TDO  output  1  serial data out = shift register bit 0.
- TDO_en  output  1  high while shifting.
- I_CODE  output  IR_WIDTH  current instruction.
- Len_err  output  1  last update followed a shift of wrong length.

Behaviour:
Reset and clocking:
- Reset: one clock, single synchronous active-low reset.
- When Test_Log_Res_n=0 at a rising TCK edge, regardless of the enables:
  - shift register <= {0..0,2'b01};
  - I_CODE <= RESET_CODE;
  - bit counter <= 0;
  - TDO_en <= 0;
  - Len_err <= 0.
- Reset asserted mid-shift aborts the shift; no partial update occurs.

Enable priority: Capture_IR > Shift_IR > Update_IR. These are mutually exclusive in a legal TAP; if several are high, only the highest-priority action is performed.

Capture_IR=1:
- shift register <= {Status_in[IR_WIDTH-1:2], 2'b01};
- bit counter <= 0.

Shift_IR=1:
- shift register <= {TDI, sr[IR_WIDTH-1:1]}, LSB first out.
- Bit counter increments, saturating at IR_WIDTH+1.

Update_IR=1:
- Let v = shift register. I_CODE <= v if VALID_MASK[v]=1, else all ones (BYPASS).
- Len_err <= (bit counter != IR_WIDTH).
- The update happens even when Len_err is set (IEEE 1149.1 compliant); Len_err is status only.
- Bit counter <= 0.

TDO and TDO_en:
- TDO is combinational from shift register bit 0.
- TDO_en is registered: TDO_en <= Shift_IR (one-cycle lag matches the falling-edge TDO timing at the pad wrapper).

Other rules:
- Idle (no enables): all registers hold.
- I_CODE changes only on update or reset, never during capture or shift.
- Latency:
  - TDI bit k appears on TDO IR_WIDTH shift cycles later;
  - the first TDO bit after capture is 1 (the "01" pattern).
- Width rules: the counter is clog2(IR_WIDTH+2) bits. RESET_CODE and VALID_MASK are truncated to their declared widths.

Decomposition:
- Package jtag_pkg holds:
  - instruction code constants BYPASS (all ones), IDCODE (1), EXTEST (0), SAMPLE (2);
  - IR_CAPTURE_LSBS = 2'b01;
  - function ir_bypass(width).
- Sub-module jtag_ir_cell_sync: one shift/capture bit with a TCK-domain shift flop, instantiated IR_WIDTH times.
- Update, validity check and the bit counter stay in the top level.

Test Plan (IR_WIDTH=4, VALID_MASK=16'h000F unless noted):
- Reset: Test_Log_Res_n=0 for 1 cycle -> I_CODE=4'b0001, TDO=1, TDO_en=0, Len_err=0.
- Capture with Status_in=4'b1100, then 4 shifts with TDI=0,1,0,0 -> TDO sequence 1,0,1,1. After Update: I_CODE=4'b0010, Len_err=0.
- Illegal opcode: shift in 4'b1010 then update -> I_CODE=4'b1111 (BYPASS), Len_err=0.
- Short shift: capture, 3 shifts of TDI=1, update -> shift register=4'b1110, I_CODE=4'b1111 (opcode 14 not in mask), Len_err=1. Next correct 4-bit shift plus update clears Len_err.
- Reset mid-shift: after 2 shift cycles, reset for 1 cycle -> I_CODE=4'b0001, shift register=4'b0001, no update. A subsequent update without a shift gives Len_err=1 and I_CODE=4'b0001.
- Simultaneous Capture_IR=1 and Update_IR=1 -> capture only; I_CODE unchanged.
